// File: rtl/plic_gw_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | plic_gw_pkg                                                        |
// | Shared types and helpers for the PLIC interrupt gateway bank.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package plic_gw_pkg;

  // Per-source gateway state
  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

  // ID 0 never names a source; it means "no interrupt"
  localparam int NO_IRQ_ID = 0;

  // Width needed to carry IDs 0..nsrc
  function automatic int id_width(input int nsrc);
    return $clog2(nsrc + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/plic_gateway_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | plic_gateway_cell                                                  |
// | One interrupt gateway: IDLE/PENDING/INFLIGHT state machine, edge   |
// | detector, saturating edge counter and sticky overflow flag.        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module plic_gateway_cell
  import plic_gw_pkg::*;
#(
  parameter int CNTW = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic src_sync,
  input  logic edge_mode,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pend,
  output logic inflight,
  output logic ovf
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  gw_state_e       state_q;
  logic            pend_q;
  logic            inflight_q;
  logic            prev_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            ovf_q;
  logic            ovf_d;

  logic            rise;
  logic            cnt_nz;
  logic            take;
  logic            dec;

  // Edge detect, take decision and counter/overflow next-state
  always_comb begin
    rise   = src_sync & ~prev_q;
    cnt_nz = |cnt_q;
    take   = (state_q == GW_IDLE) & (edge_mode ? (cnt_nz | rise) : src_sync);
    dec    = take & cnt_nz;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (!edge_mode) begin
      // Level mode keeps no edge history
      cnt_d = '0;
    end else if (rise && !dec) begin
      if (take) begin
        // The rise itself becomes the request (counter was empty)
        cnt_d = cnt_q;
      end else if (cnt_q == CNT_MAX) begin
        // No room to remember this edge
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (!rise && dec) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Gateway state machine with registered pend/inflight outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= GW_IDLE;
      pend_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      case (state_q)
        GW_IDLE: begin
          if (take) begin
            state_q <= GW_PENDING;
            pend_q  <= 1'b1;
          end
        end
        GW_PENDING: begin
          if (claim_hit) begin
            state_q    <= GW_INFLIGHT;
            pend_q     <= 1'b0;
            inflight_q <= 1'b1;
          end
        end
        GW_INFLIGHT: begin
          if (complete_hit) begin
            state_q    <= GW_IDLE;
            inflight_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= GW_IDLE;
          pend_q     <= 1'b0;
          inflight_q <= 1'b0;
        end
      endcase
    end
  end

  // Previous level, edge counter and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= src_sync;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend     = pend_q;
  assign inflight = inflight_q;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: rtl/plic_gateway_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | plic_gateway_array                                                 |
// | Bank of NSRC interrupt gateways feeding the PLIC core. Decodes the |
// | claim/complete IDs into per-source strobes (source i has ID i+1).  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module plic_gateway_array
  import plic_gw_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int IDW  = id_width(NSRC),
  parameter int CNTW = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src_sync,
  input  logic [NSRC-1:0] edge_mode,
  output logic [NSRC-1:0] pend,
  output logic [NSRC-1:0] inflight,
  output logic [NSRC-1:0] ovf,
  input  logic            claim_valid,
  input  logic [IDW-1:0]  claim_id,
  input  logic            complete_valid,
  input  logic [IDW-1:0]  complete_id
);

  logic [NSRC-1:0] claim_hit;
  logic [NSRC-1:0] complete_hit;

  for (genvar i = 0; i < NSRC; i++) begin : g_cell
    // ID 0 (NO_IRQ_ID) and IDs above NSRC match no cell, so they fall away here
    localparam logic [IDW-1:0] CELL_ID = IDW'(i + 1);

    assign claim_hit[i]    = claim_valid    & (claim_id    == CELL_ID);
    assign complete_hit[i] = complete_valid & (complete_id == CELL_ID);

    plic_gateway_cell #(
      .CNTW (CNTW)
    ) u_cell (
      .clock        (clock),
      .reset        (reset),
      .src_sync     (src_sync[i]),
      .edge_mode    (edge_mode[i]),
      .claim_hit    (claim_hit[i]),
      .complete_hit (complete_hit[i]),
      .pend         (pend[i]),
      .inflight     (inflight[i]),
      .ovf          (ovf[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_plic_gateway_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_plic_gateway_array                                              |
// | Self-checking bench for the PLIC gateway bank with a cycle-level   |
// | reference model of the gateway rules.                              |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_plic_gateway_array;

  localparam int NSRC = 8;
  localparam int CNTW = 2;
  localparam int IDW  = $clog2(NSRC + 1);
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clock = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src_sync;
  logic [NSRC-1:0] edge_mode;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] inflight;
  logic [NSRC-1:0] ovf;
  logic            claim_valid;
  logic [IDW-1:0]  claim_id;
  logic            complete_valid;
  logic [IDW-1:0]  complete_id;

  int total = 0;
  int bad   = 0;

  // Reference model: 0=idle 1=pending 2=inflight
  int m_st  [NSRC];
  int m_cnt [NSRC];
  bit m_prev[NSRC];
  bit m_ovf [NSRC];

  plic_gateway_array #(
    .NSRC (NSRC),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .src_sync       (src_sync),
    .edge_mode      (edge_mode),
    .pend           (pend),
    .inflight       (inflight),
    .ovf            (ovf),
    .claim_valid    (claim_valid),
    .claim_id       (claim_id),
    .complete_valid (complete_valid),
    .complete_id    (complete_id)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    for (int i = 0; i < NSRC; i++) begin
      if (reset) begin
        m_st[i] = 0; m_cnt[i] = 0; m_prev[i] = 0; m_ovf[i] = 0;
      end else begin
        bit rise;
        bit take;
        int nst;
        int ncnt;
        rise = src_sync[i] && !m_prev[i];
        nst  = m_st[i];
        if (!edge_mode[i]) begin
          take = (m_st[i] == 0) && src_sync[i];
          ncnt = 0;
        end else begin
          take = (m_st[i] == 0) && (m_cnt[i] > 0 || rise);
          if (take && m_cnt[i] == 0) ncnt = m_cnt[i];
          else ncnt = m_cnt[i] + int'(rise) - int'(take);
          if (ncnt > CMAX) begin
            ncnt = CMAX;
            m_ovf[i] = 1;
          end
        end
        if (take) nst = 1;
        if (claim_valid && int'(claim_id) == i + 1 && m_st[i] == 1) nst = 2;
        if (complete_valid && int'(complete_id) == i + 1 && m_st[i] == 2) nst = 0;
        m_st[i]   = nst;
        m_cnt[i]  = ncnt;
        m_prev[i] = src_sync[i];
      end
    end
  endtask

  function automatic logic [NSRC-1:0] exp_pend();
    for (int i = 0; i < NSRC; i++) exp_pend[i] = (m_st[i] == 1);
  endfunction

  function automatic logic [NSRC-1:0] exp_infl();
    for (int i = 0; i < NSRC; i++) exp_infl[i] = (m_st[i] == 2);
  endfunction

  function automatic logic [NSRC-1:0] exp_ovf();
    for (int i = 0; i < NSRC; i++) exp_ovf[i] = m_ovf[i];
  endfunction

  // Advance one clock; model consumes the same inputs the DUT samples
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_claim(input int id);
    claim_valid = 1'b1; claim_id = IDW'(id);
    tick();
    claim_valid = 1'b0; claim_id = '0;
  endtask

  task automatic do_complete(input int id);
    complete_valid = 1'b1; complete_id = IDW'(id);
    tick();
    complete_valid = 1'b0; complete_id = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++;
    if ({pend, inflight, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got pend=%b infl=%b ovf=%b want all zero", pend, inflight, ovf);
    end
  endtask

  task automatic test_level();
    src_sync[3] = 1'b1;
    tick();
    total++;
    if (pend !== 8'b0000_1000 || inflight !== '0) begin
      bad++;
      $display("FAIL level_pend got pend=%b infl=%b want pend=00001000", pend, inflight);
    end
    src_sync[3] = 1'b0;
    tick();
    do_claim(4);
    total++;
    if (pend[3] !== 1'b0 || inflight[3] !== 1'b1) begin
      bad++;
      $display("FAIL level_claim got pend3=%b infl3=%b want 0/1", pend[3], inflight[3]);
    end
    tick(); tick();
    do_complete(4);
    total++;
    if (pend !== '0 || inflight !== '0) begin
      bad++;
      $display("FAIL level_complete got pend=%b infl=%b want zero", pend, inflight);
    end
    tick();
    total++;
    if (pend !== '0 || inflight !== '0) begin
      bad++;
      $display("FAIL level_no_repend got pend=%b infl=%b want zero", pend, inflight);
    end
  endtask

  task automatic test_edge_saturation();
    edge_mode[0] = 1'b1;
    src_sync[0]  = 1'b1;
    tick();
    src_sync[0]  = 1'b0;
    do_claim(1);
    total++;
    if (inflight[0] !== 1'b1) begin
      bad++;
      $display("FAIL edge_claim got infl0=%b want 1", inflight[0]);
    end
    for (int k = 0; k < 5; k++) begin
      src_sync[0] = 1'b1; tick();
      src_sync[0] = 1'b0; tick();
    end
    total++;
    if (ovf !== 8'b0000_0001 || inflight[0] !== 1'b1 || pend[0] !== 1'b0) begin
      bad++;
      $display("FAIL edge_ovf got ovf=%b infl0=%b pend0=%b want ovf=00000001 1/0", ovf, inflight[0], pend[0]);
    end
    do_complete(1);
    tick();
    total++;
    if (pend[0] !== 1'b1) begin
      bad++;
      $display("FAIL edge_repend got pend0=%b want 1", pend[0]);
    end
    // Counter now holds 2 remembered edges: two more re-pends, then idle
    for (int r = 0; r < 3; r++) begin
      do_claim(1);
      do_complete(1);
      tick();
      total++;
      if (pend[0] !== (r < 2) || inflight[0] !== 1'b0) begin
        bad++;
        $display("FAIL edge_round%0d got pend0=%b infl0=%b want %0d/0", r, pend[0], inflight[0], (r < 2));
      end
    end
    total++;
    if (ovf[0] !== 1'b1 || pend !== exp_pend()) begin
      bad++;
      $display("FAIL edge_sticky got ovf=%b pend=%b want ovf0=1 pend=%b", ovf, pend, exp_pend());
    end
    edge_mode[0] = 1'b0;
  endtask

  task automatic test_same_cycle();
    src_sync[1] = 1'b1;
    tick();
    do_claim(2);
    src_sync[1] = 1'b0;
    src_sync[0] = 1'b1;
    tick();
    total++;
    if (pend[1:0] !== 2'b01 || inflight[1:0] !== 2'b10) begin
      bad++;
      $display("FAIL same_setup got pend=%b infl=%b want pend=01 infl=10", pend[1:0], inflight[1:0]);
    end
    claim_valid = 1'b1;    claim_id    = IDW'(1);
    complete_valid = 1'b1; complete_id = IDW'(2);
    tick();
    claim_valid = 1'b0; complete_valid = 1'b0;
    total++;
    if (pend[1:0] !== 2'b00 || inflight[1:0] !== 2'b01) begin
      bad++;
      $display("FAIL same_cycle got pend=%b infl=%b want pend=00 infl=01", pend[1:0], inflight[1:0]);
    end
    src_sync[0] = 1'b0;
    do_complete(1);
  endtask

  task automatic test_illegal_ids();
    int ids[4];
    bit is_claim[4];
    ids = '{0, NSRC + 1, 6, 5};
    is_claim = '{1, 1, 1, 0};
    src_sync[4] = 1'b1;
    tick();
    src_sync[4] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (is_claim[k]) do_claim(ids[k]);
      else do_complete(ids[k]);
      total++;
      if (pend !== 8'b0001_0000 || inflight !== '0) begin
        bad++;
        $display("FAIL illegal_id%0d got pend=%b infl=%b want pend=00010000 infl=0", ids[k], pend, inflight);
      end
    end
    do_claim(5);
    do_complete(5);
  endtask

  task automatic test_reset_release_edge();
    edge_mode[2] = 1'b1;
    src_sync[2]  = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++;
    if ({pend, inflight, ovf} !== '0) begin
      bad++;
      $display("FAIL rel_in_reset got pend=%b infl=%b ovf=%b want zero", pend, inflight, ovf);
    end
    tick();
    total++;
    if (pend !== 8'b0000_0100) begin
      bad++;
      $display("FAIL rel_pend got pend=%b want 00000100", pend);
    end
    do_claim(3);
    do_complete(3);
    tick(); tick();
    total++;
    if (pend !== '0 || inflight !== '0) begin
      bad++;
      $display("FAIL rel_held_high got pend=%b infl=%b want zero", pend, inflight);
    end
    src_sync[2]  = 1'b0;
    edge_mode[2] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    src_sync[7:5] = 3'b111;
    edge_mode[1]  = 1'b1;
    src_sync[1]   = 1'b1;
    tick();
    src_sync[1]   = 1'b0;
    do_claim(6); do_claim(7); do_claim(8);
    src_sync[7:5] = 3'b000;
    for (int k = 0; k < 2; k++) begin
      src_sync[1] = 1'b1; tick();
      src_sync[1] = 1'b0; tick();
    end
    total++;
    if (inflight !== 8'b1110_0000 || pend !== 8'b0000_0010) begin
      bad++;
      $display("FAIL mid_setup got pend=%b infl=%b want pend=00000010 infl=11100000", pend, inflight);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({pend, inflight, ovf} !== '0) begin
      bad++;
      $display("FAIL mid_reset got pend=%b infl=%b ovf=%b want zero", pend, inflight, ovf);
    end
    tick(); tick(); tick();
    total++;
    if ({pend, inflight, ovf} !== '0) begin
      bad++;
      $display("FAIL mid_cnt_cleared got pend=%b infl=%b ovf=%b want zero", pend, inflight, ovf);
    end
    edge_mode[1] = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        if ($urandom_range(0, 3) == 0) src_sync[i] = ~src_sync[i];
        if ($urandom_range(0, 40) == 0) edge_mode[i] = ~edge_mode[i];
      end
      claim_valid    = ($urandom_range(0, 1) == 1);
      claim_id       = IDW'($urandom_range(0, NSRC + 2));
      complete_valid = ($urandom_range(0, 1) == 1);
      complete_id    = IDW'($urandom_range(0, NSRC + 2));
      reset          = ($urandom_range(0, 149) == 0);
      tick();
      total++;
      if (pend !== exp_pend() || inflight !== exp_infl() || ovf !== exp_ovf()) begin
        bad++;
        $display("FAIL random_c%0d got pend=%b infl=%b ovf=%b want pend=%b infl=%b ovf=%b",
                 c, pend, inflight, ovf, exp_pend(), exp_infl(), exp_ovf());
      end
    end
    reset = 1'b0; claim_valid = 1'b0; complete_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    src_sync       = '0;
    edge_mode      = '0;
    claim_valid    = 1'b0;
    claim_id       = '0;
    complete_valid = 1'b0;
    complete_id    = '0;
    test_reset();
    test_level();
    test_edge_saturation();
    test_same_cycle();
    test_illegal_ids();
    test_reset_release_edge();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
